periph_bus_arbiter: RTL
=======================

Name: periph_bus_arbiter

Overview:
Two-master arbiter for the single peripheral/data-memory bus (MemAddr/MemRead/MemWrite/MemWriteData/MemReadData) between the CPU core and the Peripheral block.
- Master 0 is the single-cycle core and has default priority.
- Master 1 is a secondary bus master, e.g. a UART loader or DMA engine.
- Adds starvation protection for M1, a locked atomic sequence for M1 with a timeout, and registered read-data return to each master.
- Sits in the top level between the core, the second master and Peripheral.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive M0 grants while M1 is requesting; M1 then gets the next grant
LOCK_MAX, 16, max cycles M1 may hold the bus lock before forced release

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  M0 transaction valid
m0_wr  in  1  1=write, 0=read
m0_addr  in  ADDR_W  M0 address
m0_wdata  in  DATA_W  M0 write data
m0_gnt  out  1  M0 transaction accepted this cycle (combinational)
m0_rdata  out  DATA_W  M0 read data (registered)
m0_rvalid  out  1  M0 read data valid pulse
m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same as M0, for M1
m1_lock  in  1  M1 requests the bus stay locked after this transaction
oMemRead  out  1  bus read strobe
oMemWrite  out  1  bus write strobe
oMemAddr  out  ADDR_W  bus address
oMemWriteData  out  DATA_W  bus write data
iMemReadData  in  DATA_W  bus read data, valid in the same cycle as oMemRead
oLockErr  out  1  one-cycle pulse when the lock timeout fires

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Handshake: valid/ready.
  - A transaction completes in a cycle where mX_req=1 and mX_gnt=1.
  - Masters hold req/wr/addr/wdata stable until granted; they may change them in the cycle after the grant.
  - At most one gnt is high per cycle.
  - gnt is forced 0 while reset=1.
- Grant rule, evaluated combinationally from req and registered state:
  - lock_r=1: only M1 can be granted. M0 gnt=0 even if M1 is idle.
  - lock_r=0, both requesting: M1 granted if starve_cnt==STARVE_LIMIT, else M0.
  - lock_r=0, single requester: that master is granted.
- Bus drive:
  - Granted master's request: oMemRead=~wr, oMemWrite=wr, oMemAddr=addr, oMemWriteData=wdata.
  - No grant: all bus outputs 0.
- Read return:
  - On a granted read, iMemReadData is registered into that master's rdata.
  - That master's rvalid=1 for exactly the next cycle.
  - rdata holds its last value otherwise.
  - Writes produce no rvalid.
- starve_cnt (width covers STARVE_LIMIT):
  - +1 when M0 is granted while m1_req=1, saturating at STARVE_LIMIT.
  - Cleared when M1 is granted or when m1_req=0.
- Lock:
  - lock_r set on an M1 grant with m1_lock=1; cleared on an M1 grant with m1_lock=0.
  - lock_cnt counts cycles with lock_r=1 and is cleared when lock_r clears.
  - When lock_cnt reaches LOCK_MAX-1 with no releasing grant: lock_r clears on the next edge and oLockErr pulses for 1 cycle.
  - A locking grant that coincides with timeout re-arms the lock: lock_r stays 1, lock_cnt=0, no error pulse.
- Reset values: all outputs 0; starve_cnt=0, lock_r=0, lock_cnt=0. Reset mid-lock or mid-read drops the lock and suppresses the pending rvalid.
- Latency: grant in 0 cycles when the bus is free; read data 1 cycle after grant. Back-to-back grants every cycle are supported.

Test Plan:
- Only M0 reads addr 0x40000010 with bus data 0xA5 → m0_gnt same cycle, oMemRead=1, oMemAddr=0x40000010; next cycle m0_rvalid=1, m0_rdata=0xA5.
- M0 and M1 requesting continuously, STARVE_LIMIT=4 → grant order M0,M0,M0,M0,M1 repeating; never two gnts in one cycle.
- M1 write with m1_lock=1, then M0 requests for 3 idle cycles, then M1 write with m1_lock=0 → m0_gnt=0 throughout; M0 granted the cycle after the unlock.
- M1 locks and then goes idle, LOCK_MAX=16 → oLockErr pulses once 16 cycles after the locking grant; M0 granted the following cycle.
- Reset asserted the cycle after an M0 read grant → m0_rvalid stays 0; all bus outputs, gnts and lock are 0 after reset.
- No requests → oMemRead=oMemWrite=0, oMemAddr=0, oMemWriteData=0, no rvalid.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the shared peripheral/data-memory bus: M0 (core) has default
// priority, M1 gets starvation protection and a time-limited bus lock.
module periph_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWriteData,
  input  logic [DATA_W-1:0] iMemReadData,
  output logic              oLockErr
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic [SW-1:0] starve_cnt;
  logic          lock_r;
  logic [LW-1:0] lock_cnt;
  logic          m0_rv_r;
  logic          m1_rv_r;
  logic          timeout;

  always_comb begin
    m1_gnt   = !reset && m1_req &&
               (lock_r || !m0_req || starve_cnt == SW'(STARVE_LIMIT));
    m0_gnt   = !reset && m0_req && !lock_r && !m1_gnt;
    timeout  = lock_r && lock_cnt == LW'(LOCK_MAX - 1);
    // A granted M1 transaction at the timeout cycle either releases or re-arms the lock.
    oLockErr = !reset && timeout && !m1_gnt;

    oMemRead      = 1'b0;
    oMemWrite     = 1'b0;
    oMemAddr      = '0;
    oMemWriteData = '0;
    if (m0_gnt) begin
      oMemRead      = !m0_wr;
      oMemWrite     = m0_wr;
      oMemAddr      = m0_addr;
      oMemWriteData = m0_wdata;
    end else if (m1_gnt) begin
      oMemRead      = !m1_wr;
      oMemWrite     = m1_wr;
      oMemAddr      = m1_addr;
      oMemWriteData = m1_wdata;
    end
  end

  // Pending read returns are masked while reset is held.
  assign m0_rvalid = m0_rv_r && !reset;
  assign m1_rvalid = m1_rv_r && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rv_r    <= 1'b0;
      m1_rv_r    <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      starve_cnt <= '0;
      lock_r     <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      m0_rv_r <= m0_gnt && !m0_wr;
      m1_rv_r <= m1_gnt && !m1_wr;
      if (m0_gnt && !m0_wr) m0_rdata <= iMemReadData;
      if (m1_gnt && !m1_wr) m1_rdata <= iMemReadData;

      if (m1_gnt || !m1_req)
        starve_cnt <= '0;
      else if (m0_gnt && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      if (m1_gnt)
        lock_r <= m1_lock;
      else if (timeout)
        lock_r <= 1'b0;

      if ((m1_gnt && !m1_lock) || timeout)
        lock_cnt <= '0;
      else if (lock_r)
        lock_cnt <= lock_cnt + 1'b1;
    end
  end

endmodule
